// File: rtl/calc_if.sv
`default_nettype none
// ============================================================================
//  Module      : calc_if
//  Description : start/busy/done request bus between a front-end sequencer
//                (master) and the calc_secuencial engine (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface calc_if #(
    parameter int WIDTH = 4
);
    logic                   start;
    logic [2:0]             op;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     resul;
    logic                   err;

    modport master (
        output start, op, a, b,
        input  busy, done, resul, err
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, resul, err
    );
endinterface
`default_nettype wire

// File: rtl/calc_secuencial.sv
`default_nettype none
// ============================================================================
//  Module      : calc_secuencial
//  Description : multi-cycle calculator (sum/res/mul/div/por, optional pot)
//                with iterative shift-add multiply and restoring divide.
//                Optional feature macro: CALC_POT_EN (op=5, power).
//  Revision    : 1.0 - initial release
// ============================================================================
module calc_secuencial #(
    parameter int WIDTH   = 4,
    parameter int PCT_DIV = 100
) (
    input  wire logic clk,
    input  wire logic rst,
    calc_if.slave     bus
);

    localparam int CNT_W = WIDTH + 2;

    localparam logic [2:0] OP_SUM = 3'd0;
    localparam logic [2:0] OP_RES = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_POR = 3'd4;
`ifdef CALC_POT_EN
    localparam logic [2:0] OP_POT = 3'd5;
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q;
    logic [2:0]           op_q;
    logic [2*WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]     mplier_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [2*WIDTH-1:0]   dvd_q;
    logic [2*WIDTH-1:0]   rem_q;
    logic [2*WIDTH-1:0]   dvs_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 phase_q;
    logic                 errp_q;
    logic                 busy_q;
    logic                 done_q;
    logic [2*WIDTH-1:0]   resul_q;
    logic                 err_q;

    // One shift-add multiply step
    logic [2*WIDTH-1:0]   mul_acc_d;
    assign mul_acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

    // One restoring-divide step; the quotient bit shifts into the dividend LSB
    logic [2*WIDTH:0]     div_shift;
    logic                 div_ge;
    logic [2*WIDTH-1:0]   div_sub;
    logic [2*WIDTH-1:0]   div_rem_d;
    logic [2*WIDTH-1:0]   div_dvd_d;
    assign div_shift = {rem_q, dvd_q[2*WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, dvs_q};
    assign div_sub   = div_shift[2*WIDTH-1:0] - dvs_q;
    assign div_rem_d = div_ge ? div_sub : div_shift[2*WIDTH-1:0];
    assign div_dvd_d = {dvd_q[2*WIDTH-2:0], div_ge};

`ifdef CALC_POT_EN
    logic [3*WIDTH-1:0]   pow_full;
    logic                 pow_ovf;
    assign pow_full = {{WIDTH{1'b0}}, acc_q} * {{(2*WIDTH){1'b0}}, mcand_q[WIDTH-1:0]};
    assign pow_ovf  = |pow_full[3*WIDTH-1:2*WIDTH];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            dvd_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            errp_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            resul_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        op_q     <= bus.op;
                        mcand_q  <= {{WIDTH{1'b0}}, bus.a};
                        mplier_q <= bus.b;
                        acc_q    <= '0;
                        dvd_q    <= {bus.a, {WIDTH{1'b0}}};
                        rem_q    <= '0;
                        dvs_q    <= {{WIDTH{1'b0}}, bus.b};
                        cnt_q    <= CNT_W'(WIDTH);
                        phase_q  <= 1'b0;
                        errp_q   <= 1'b0;
                        err_q    <= 1'b0;
                        state_q  <= S_CALC;
                        busy_q   <= 1'b1;
                        case (bus.op)
                            OP_SUM: begin
                                acc_q   <= {{WIDTH{1'b0}}, bus.a} + {{WIDTH{1'b0}}, bus.b};
                                state_q <= S_DONE;
                                busy_q  <= 1'b0;
                            end
                            OP_RES: begin
                                acc_q   <= {{WIDTH{1'b0}}, bus.a} - {{WIDTH{1'b0}}, bus.b};
                                state_q <= S_DONE;
                                busy_q  <= 1'b0;
                            end
                            OP_MUL, OP_POR: begin
                            end
                            OP_DIV: begin
                                if (bus.b == '0) begin
                                    acc_q   <= '1;
                                    errp_q  <= 1'b1;
                                    state_q <= S_DONE;
                                    busy_q  <= 1'b0;
                                end
                            end
`ifdef CALC_POT_EN
                            OP_POT: begin
                                acc_q <= {{(2*WIDTH-1){1'b0}}, 1'b1};
                                cnt_q <= {2'b00, bus.b};
                                if (bus.b == '0) begin
                                    state_q <= S_DONE;
                                    busy_q  <= 1'b0;
                                end
                            end
`endif
                            default: begin
                                errp_q  <= 1'b1;
                                state_q <= S_DONE;
                                busy_q  <= 1'b0;
                            end
                        endcase
                    end
                end

                S_CALC: begin
                    cnt_q <= cnt_q - 1'b1;
                    if (op_q == OP_DIV || phase_q) begin
                        rem_q <= div_rem_d;
                        dvd_q <= div_dvd_d;
                    end
`ifdef CALC_POT_EN
                    else if (op_q == OP_POT) begin
                        acc_q <= pow_full[2*WIDTH-1:0];
                        if (pow_ovf)
                            errp_q <= 1'b1;
                    end
`endif
                    else begin
                        acc_q    <= mul_acc_d;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                    end

                    if (cnt_q == CNT_W'(1)) begin
                        // Percent: the finished product becomes the dividend
                        if (op_q == OP_POR && !phase_q) begin
                            phase_q <= 1'b1;
                            cnt_q   <= CNT_W'(2 * WIDTH);
                            dvd_q   <= mul_acc_d;
                            rem_q   <= '0;
                            dvs_q   <= (2*WIDTH)'(PCT_DIV);
                        end else begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            if (op_q == OP_DIV)
                                acc_q <= {div_rem_d[WIDTH-1:0], div_dvd_d[WIDTH-1:0]};
                            else if (op_q == OP_POR)
                                acc_q <= div_dvd_d;
`ifdef CALC_POT_EN
                            else if (op_q == OP_POT && (errp_q || pow_ovf))
                                acc_q <= '1;
`endif
                        end
                    end
                end

                S_DONE: begin
                    resul_q <= acc_q;
                    err_q   <= errp_q;
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.resul = resul_q;
    assign bus.err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_secuencial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_calc_secuencial
//  Description : directed self-checking bench for calc_secuencial (WIDTH=4).
//                Honours CALC_POT_EN for the power operation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_calc_secuencial;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;
    int   vectors     = 0;
    int   miscompares = 0;

    calc_if #(.WIDTH(W)) bus ();

    calc_secuencial #(.WIDTH(W), .PCT_DIV(100)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Issues one request; poke_at>0 re-pulses start (op0, a=1) that many cycles after accept
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int poke_at, output int lat, output int busy_n, output int overlap);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = -1; busy_n = 0; overlap = 0;
        for (int n = 1; n <= 100; n++) begin
            if (bus.busy) busy_n++;
            if (n == poke_at) begin
                bus.start = 1'b1; bus.op = 3'd0; bus.a = 4'd1;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (bus.busy && bus.done) overlap++;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({bus.busy, bus.done, bus.err} !== 3'b000 || bus.resul !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_outputs: busy/done/err=%b resul=%h expected 000 / 00",
                     {bus.busy, bus.done, bus.err}, bus.resul);
        end
        rst = 1'b0;
    endtask

    task automatic test_sum_res();
        int lat, bn, ov;
        run_op(3'd0, 4'd9, 4'd7, 0, lat, bn, ov);
        vectors++;
        if (lat !== 1 || bus.resul !== 8'h10 || bus.err !== 1'b0 || bn !== 0 || ov !== 0) begin
            miscompares++;
            $display("FAIL sum_9_7: lat=%0d resul=%h err=%b busy_cycles=%0d expected lat=1 resul=10 err=0 busy_cycles=0",
                     lat, bus.resul, bus.err, bn);
        end
        run_op(3'd1, 4'd3, 4'd5, 0, lat, bn, ov);
        vectors++;
        if (lat !== 1 || bus.resul !== 8'hFE || bus.err !== 1'b0) begin
            miscompares++;
            $display("FAIL res_3_5: lat=%0d resul=%h err=%b expected lat=1 resul=fe err=0",
                     lat, bus.resul, bus.err);
        end
    endtask

    task automatic test_mul();
        int lat, bn, ov;
        run_op(3'd2, 4'd15, 4'd15, 0, lat, bn, ov);
        vectors++;
        if (lat !== 5 || bus.resul !== 8'd225 || bus.err !== 1'b0 || bn !== 4 || ov !== 0) begin
            miscompares++;
            $display("FAIL mul_15_15: lat=%0d resul=%0d busy_cycles=%0d overlap=%0d expected lat=5 resul=225 busy_cycles=4 overlap=0",
                     lat, bus.resul, bn, ov);
        end
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (bus.resul !== 8'd225 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL mul_hold: resul=%0d done=%b expected 225 / 0", bus.resul, bus.done);
        end
        run_op(3'd2, 4'd6, 4'd5, 0, lat, bn, ov);
        vectors++;
        if (lat !== 5 || bus.resul !== 8'd30) begin
            miscompares++;
            $display("FAIL mul_6_5: lat=%0d resul=%0d expected lat=5 resul=30", lat, bus.resul);
        end
    endtask

    task automatic test_div();
        int lat, bn, ov;
        run_op(3'd3, 4'd13, 4'd4, 0, lat, bn, ov);
        vectors++;
        if (lat !== 5 || bus.resul !== 8'h13 || bus.err !== 1'b0) begin
            miscompares++;
            $display("FAIL div_13_4: lat=%0d resul=%h err=%b expected lat=5 resul=13 err=0",
                     lat, bus.resul, bus.err);
        end
        run_op(3'd3, 4'd15, 4'd1, 0, lat, bn, ov);
        vectors++;
        if (lat !== 5 || bus.resul !== 8'h0F) begin
            miscompares++;
            $display("FAIL div_15_1: lat=%0d resul=%h expected lat=5 resul=0f", lat, bus.resul);
        end
        run_op(3'd3, 4'd9, 4'd0, 0, lat, bn, ov);
        vectors++;
        if (lat !== 1 || bus.resul !== 8'hFF || bus.err !== 1'b1) begin
            miscompares++;
            $display("FAIL div_by_zero: lat=%0d resul=%h err=%b expected lat=1 resul=ff err=1",
                     lat, bus.resul, bus.err);
        end
        run_op(3'd0, 4'd2, 4'd3, 0, lat, bn, ov);
        vectors++;
        if (bus.err !== 1'b0 || bus.resul !== 8'h05) begin
            miscompares++;
            $display("FAIL err_clears: resul=%h err=%b expected 05 / 0", bus.resul, bus.err);
        end
    endtask

    task automatic test_por();
        int lat, bn, ov;
        run_op(3'd4, 4'd15, 4'd15, 4, lat, bn, ov);
        vectors++;
        if (lat !== 13 || bus.resul !== 8'd2 || bus.err !== 1'b0 || bn !== 12 || ov !== 0) begin
            miscompares++;
            $display("FAIL por_15_15: lat=%0d resul=%0d err=%b busy_cycles=%0d expected lat=13 resul=2 err=0 busy_cycles=12",
                     lat, bus.resul, bus.err, bn);
        end
        run_op(3'd4, 4'd12, 4'd10, 0, lat, bn, ov);
        vectors++;
        if (lat !== 13 || bus.resul !== 8'd1) begin
            miscompares++;
            $display("FAIL por_12_10: lat=%0d resul=%0d expected lat=13 resul=1", lat, bus.resul);
        end
    endtask

    task automatic test_reset_midop();
        int lat, bn, ov;
        int seen;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd2; bus.a = 4'd7; bus.b = 4'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vectors++;
        if ({bus.busy, bus.done, bus.err} !== 3'b000 || bus.resul !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_midop: busy/done/err=%b resul=%h expected 000 / 00",
                     {bus.busy, bus.done, bus.err}, bus.resul);
        end
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            miscompares++;
            $display("FAIL reset_abandon: activity_cycles=%0d expected 0", seen);
        end
        run_op(3'd0, 4'd1, 4'd1, 0, lat, bn, ov);
        vectors++;
        if (lat !== 1 || bus.resul !== 8'h02) begin
            miscompares++;
            $display("FAIL after_reset_sum: lat=%0d resul=%h expected lat=1 resul=02", lat, bus.resul);
        end
    endtask

    task automatic test_back_to_back();
        int pulses;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd0; bus.a = 4'd1; bus.b = 4'd2;
        repeat (2) @(posedge clk);
        #1;
        bus.start = 1'b0;
        pulses = 0;
        repeat (6) begin
            if (bus.done) pulses++;
            @(posedge clk); #1;
        end
        vectors++;
        if (pulses !== 1 || bus.resul !== 8'h03) begin
            miscompares++;
            $display("FAIL start_in_done: done_pulses=%0d resul=%h expected 1 / 03", pulses, bus.resul);
        end
    endtask

    task automatic test_illegal_pot();
        int lat, bn, ov;
        run_op(3'd6, 4'd5, 4'd5, 0, lat, bn, ov);
        vectors++;
        if (lat !== 1 || bus.resul !== 8'h00 || bus.err !== 1'b1) begin
            miscompares++;
            $display("FAIL illegal_6: lat=%0d resul=%h err=%b expected lat=1 resul=00 err=1",
                     lat, bus.resul, bus.err);
        end
        run_op(3'd7, 4'd3, 4'd3, 0, lat, bn, ov);
        vectors++;
        if (lat !== 1 || bus.resul !== 8'h00 || bus.err !== 1'b1) begin
            miscompares++;
            $display("FAIL illegal_7: lat=%0d resul=%h err=%b expected lat=1 resul=00 err=1",
                     lat, bus.resul, bus.err);
        end
`ifdef CALC_POT_EN
        run_op(3'd5, 4'd2, 4'd3, 0, lat, bn, ov);
        vectors++;
        if (lat !== 4 || bus.resul !== 8'd8 || bus.err !== 1'b0) begin
            miscompares++;
            $display("FAIL pot_2_3: lat=%0d resul=%0d err=%b expected lat=4 resul=8 err=0",
                     lat, bus.resul, bus.err);
        end
        run_op(3'd5, 4'd15, 4'd3, 0, lat, bn, ov);
        vectors++;
        if (lat !== 4 || bus.resul !== 8'hFF || bus.err !== 1'b1) begin
            miscompares++;
            $display("FAIL pot_15_3: lat=%0d resul=%h err=%b expected lat=4 resul=ff err=1",
                     lat, bus.resul, bus.err);
        end
        run_op(3'd5, 4'd9, 4'd0, 0, lat, bn, ov);
        vectors++;
        if (lat !== 1 || bus.resul !== 8'h01 || bus.err !== 1'b0) begin
            miscompares++;
            $display("FAIL pot_b0: lat=%0d resul=%h err=%b expected lat=1 resul=01 err=0",
                     lat, bus.resul, bus.err);
        end
`else
        run_op(3'd5, 4'd2, 4'd3, 0, lat, bn, ov);
        vectors++;
        if (lat !== 1 || bus.resul !== 8'h00 || bus.err !== 1'b1) begin
            miscompares++;
            $display("FAIL pot_disabled: lat=%0d resul=%h err=%b expected lat=1 resul=00 err=1",
                     lat, bus.resul, bus.err);
        end
`endif
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 3'd0;
        bus.a     = '0;
        bus.b     = '0;
        test_reset();
        test_sum_res();
        test_mul();
        test_div();
        test_por();
        test_reset_midop();
        test_back_to_back();
        test_illegal_pot();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/calc_secuencial.md
Name: calc_secuencial

Overview:
Multi-cycle, parametrised successor of the combinational 4-bit calculator family (sum/res/mul/div/pot/por).
- Single operator-select port replaces one-module-per-operation.
- Operand width is parametrised.
- Multiply and divide are iterative (shift-add / restoring) so area stays flat as WIDTH grows.
- start/busy/done handshake lets a front-end controller (keypad/display sequencer) issue one operation at a time.

Parameters:
WIDTH, 4, operand width in bits (>= 4); result is 2*WIDTH bits
PCT_DIV, 100, constant divisor used by the percent operation (must fit in 2*WIDTH bits)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request; accepted only on a clk edge where busy=0
op  input  3  operation: 0 sum, 1 res, 2 mul, 3 div, 4 por, 5 pot (optional), 6-7 illegal
a  input  WIDTH  operand A, unsigned, captured on accept
b  input  WIDTH  operand B, unsigned, captured on accept
busy  output  1  high from the cycle after accept until done is asserted
done  output  1  one-cycle pulse; resul/err valid from this cycle
resul  output  2*WIDTH  result, held stable until next accept
err  output  1  error flag for the current result, held with resul

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE; busy=0, done=0, resul=0, err=0; any operation in flight is abandoned with no done pulse. rst has priority over start.
- FSM states:
  - IDLE: start=1 -> latch a, b, op; clear err; go to CALC (or DONE for single-cycle ops).
  - CALC: iterate until counter expires, then go to DONE.
  - DONE: done=1, busy=0, return to IDLE. A start in DONE is ignored.
- start while busy=1 or in DONE: ignored, no side effects, latched operands unchanged.
- Latency, with accept at edge k (done high in the cycle after the given edge):
  - sum/res/illegal/div-by-0: done at edge k+1.
  - mul, div: done at edge k+WIDTH+1.
  - por: done at edge k+3*WIDTH+1.
- sum: resul = zero-extended a+b; carry lands in bit WIDTH.
- res: resul = (a-b) mod 2^(2*WIDTH), i.e. two's complement wrap (3-5, WIDTH=4 -> 8'hFE); err=0.
- mul: shift-add, one bit of b per cycle; resul = a*b exact (never overflows 2*WIDTH).
- div: restoring, one quotient bit per cycle.
  - resul[WIDTH-1:0] = quotient; resul[2*WIDTH-1:WIDTH] = remainder.
  - b=0: err=1, resul = all ones, no iteration.
- por: product a*b (WIDTH cycles), then restoring divide of the 2*WIDTH-bit product by PCT_DIV (2*WIDTH cycles); resul = floor(a*b/PCT_DIV); remainder discarded; err=0.
- illegal op (6, 7, or 5 without the feature): err=1, resul=0.
- busy and done are never high in the same cycle.

Optional Feature:
CALC_POT_EN
- Defined: op=5 computes a**b by repeated multiply, one cycle per step using a WIDTH x 2*WIDTH multiplier truncated to 2*WIDTH.
  - b=0 -> resul=1, done at k+1.
  - Otherwise done at edge k+b+1.
  - If any intermediate exceeds 2^(2*WIDTH)-1: resul = all ones, err=1; iteration still runs b steps.
- Not defined: no power datapath is synthesised; op=5 is illegal (err=1, resul=0, done at k+1).

Test Plan:
- WIDTH=4, op=0, a=9, b=7, start 1 cycle -> done at k+1, resul=8'h10, err=0, busy low throughout.
- op=1, a=3, b=5 -> resul=8'hFE, err=0; then op=2, a=15, b=15 -> busy 4 cycles, done at k+5, resul=225.
- op=3, a=13, b=4 -> done at k+5, resul=8'h13 (rem 1, quot 3); op=3, b=0 -> done at k+1, resul=8'hFF, err=1.
- op=4, a=15, b=15 -> done at k+13, resul=2; start pulsed again mid-operation with a=1 -> ignored, result unchanged.
- Start op=2 (a=7, b=7), assert rst at edge k+2 -> no done pulse; busy=0, resul=0 next cycle; new op=0 (a=1, b=1) accepted immediately -> resul=2.
- CALC_POT_EN defined: op=5, a=2, b=3 -> done at k+4, resul=8; a=15, b=3 -> resul=8'hFF, err=1. Undefined: op=5 -> err=1, resul=0 at k+1.
